gate_response_checker: RTL and testbench

Synthesizable response checker for exhaustive two-input gate tests. The stimulus side applies one `{a,b}` vector at a time to a gate under test. This block accepts each vector through a valid/ready handshake, waits a programmable settle time, then samples the gate output and compares it against a parameterised truth table. It accumulates coverage and error statistics and flags completion once all four input combinations have been checked.

---
 rtl/gate_response_checker.sv | 119 +++++++++++
 tb/tb_gate_response_checker.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/gate_response_checker.sv
// Response checker for exhaustive two-input gate tests: accepts {a,b} vectors, waits a settle
// time, compares the gate output against TRUTH and accumulates coverage/error statistics.
module gate_response_checker #(
    parameter logic [3:0]  TRUTH  = 4'b1000,
    parameter int unsigned SETTLE = 2,
    parameter int unsigned ERR_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             vec_valid,
    output logic             vec_ready,
    input  logic             a_in,
    input  logic             b_in,
    input  logic             c_in,
    output logic             busy,
    output logic             mismatch,
    output logic [ERR_W-1:0] err_count,
    output logic [3:0]       covered,
    output logic             first_err_valid,
    output logic [1:0]       first_err_vec,
    output logic             done,
    output logic             pass
);

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [1:0]       vec_q, vec_d;
    logic             mismatch_q, mismatch_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [3:0]       cov_q, cov_d;
    logic             fe_valid_q, fe_valid_d;
    logic [1:0]       fe_vec_q, fe_vec_d;

    logic             compare;
    logic             fail;
    logic [3:0]       cov_set;

    // The compare edge is the one on which the settle counter reaches zero.
    assign compare = (state_q == StWait) && (cnt_q == 4'd1);
    assign fail    = compare && (c_in != TRUTH[vec_q]);
    assign cov_set = cov_q | (4'b0001 << vec_q);

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            vec_q      <= '0;
            mismatch_q <= 1'b0;
            err_q      <= '0;
            cov_q      <= '0;
            fe_valid_q <= 1'b0;
            fe_vec_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            vec_q      <= vec_d;
            mismatch_q <= mismatch_d;
            err_q      <= err_d;
            cov_q      <= cov_d;
            fe_valid_q <= fe_valid_d;
            fe_vec_q   <= fe_vec_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        vec_d      = vec_q;
        mismatch_d = 1'b0;
        err_d      = err_q;
        cov_d      = cov_q;
        fe_valid_d = fe_valid_q;
        fe_vec_d   = fe_vec_q;
        case (state_q)
            StIdle: begin
                if (vec_valid) begin
                    vec_d   = {a_in, b_in};
                    cnt_d   = 4'(SETTLE);
                    state_d = StWait;
                end
            end
            StWait: begin
                cnt_d = cnt_q - 4'd1;
                if (compare) begin
                    cov_d   = cov_set;
                    state_d = (cov_set == 4'b1111) ? StDone : StIdle;
                    if (fail) begin
                        mismatch_d = 1'b1;
                        if (err_q != {ERR_W{1'b1}}) begin
                            err_d = err_q + ERR_W'(1);
                        end
                        if (!fe_valid_q) begin
                            fe_valid_d = 1'b1;
                            fe_vec_d   = vec_q;
                        end
                    end
                end
            end
            StDone: ;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        vec_ready       = (state_q == StIdle);
        busy            = (state_q == StWait);
        done            = (state_q == StDone);
        pass            = (state_q == StDone) && (err_q == '0);
        mismatch        = mismatch_q;
        err_count       = err_q;
        covered         = cov_q;
        first_err_valid = fe_valid_q;
        first_err_vec   = fe_vec_q;
    end

endmodule

// File: tb/tb_gate_response_checker.sv
// Bench for gate_response_checker: two instances (ERR_W 8 and 2) share one stimulus stream and
// are compared every cycle against a transaction-level model of the checker's statistics.
module tb_gate_response_checker;

    localparam int unsigned SETTLE = 2;

    logic clk = 1'b0;
    logic rst_n, clear, vec_valid, a_in, b_in, c_in;

    logic       ready8, busy8, mm8, fv8, done8, pass8;
    logic [7:0] err8;
    logic [3:0] cov8;
    logic [1:0] fev8;
    logic       ready2, busy2, mm2, fv2, done2, pass2;
    logic [1:0] err2;
    logic [3:0] cov2;
    logic [1:0] fev2;

    int n_chk  = 0;
    int n_pass = 0;

    int         m_err8, m_err2;
    logic [3:0] m_cov;
    logic       m_fv;
    logic [1:0] m_fev;
    logic       m_done;

    always #5 clk = ~clk;

    gate_response_checker #(.TRUTH(4'b1000), .SETTLE(SETTLE), .ERR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .vec_valid(vec_valid), .vec_ready(ready8),
        .a_in(a_in), .b_in(b_in), .c_in(c_in), .busy(busy8), .mismatch(mm8),
        .err_count(err8), .covered(cov8), .first_err_valid(fv8), .first_err_vec(fev8),
        .done(done8), .pass(pass8)
    );

    gate_response_checker #(.TRUTH(4'b1000), .SETTLE(SETTLE), .ERR_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .clear(clear), .vec_valid(vec_valid), .vec_ready(ready2),
        .a_in(a_in), .b_in(b_in), .c_in(c_in), .busy(busy2), .mismatch(mm2),
        .err_count(err2), .covered(cov2), .first_err_valid(fv2), .first_err_vec(fev2),
        .done(done2), .pass(pass2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_err8 = 0;
        m_err2 = 0;
        m_cov  = 4'b0000;
        m_fv   = 1'b0;
        m_fev  = 2'b00;
        m_done = 1'b0;
    endtask

    // A gate is good when its output equals a AND b; errors saturate at the counter width.
    task automatic model_compare(input logic a, input logic b, input logic c, output logic bad);
        int v;
        v   = {30'd0, a, b};
        bad = (c !== (a & b));
        if (bad) begin
            m_err8 = (m_err8 < 255) ? m_err8 + 1 : 255;
            m_err2 = (m_err2 < 3) ? m_err2 + 1 : 3;
            if (!m_fv) begin
                m_fv  = 1'b1;
                m_fev = {a, b};
            end
        end
        m_cov[v] = 1'b1;
        m_done   = (m_cov == 4'b1111);
    endtask

    task automatic check_all(input logic er, input logic eb, input logic emm);
        chk("ready8", ready8, er);
        chk("busy8", busy8, eb);
        chk("mismatch8", mm8, emm);
        chk("err_count8", err8, m_err8);
        chk("covered8", cov8, m_cov);
        chk("first_err_valid8", fv8, m_fv);
        chk("first_err_vec8", fev8, m_fev);
        chk("done8", done8, m_done);
        chk("pass8", pass8, m_done && (m_err8 == 0));
        chk("ready2", ready2, er);
        chk("busy2", busy2, eb);
        chk("mismatch2", mm2, emm);
        chk("err_count2", err2, m_err2);
        chk("covered2", cov2, m_cov);
        chk("first_err_valid2", fv2, m_fv);
        chk("first_err_vec2", fev2, m_fev);
        chk("done2", done2, m_done);
        chk("pass2", pass2, m_done && (m_err2 == 0));
    endtask

    // One full transaction; with keep=1 vec_valid stays high throughout (back-to-back handshake)
    task automatic do_vec(input logic a, input logic b, input logic c, input bit keep);
        logic bad;
        chk("ready_at_offer8", ready8, 1'b1);
        chk("ready_at_offer2", ready2, 1'b1);
        vec_valid = 1'b1;
        a_in = a;
        b_in = b;
        c_in = c;
        tick();
        if (!keep) vec_valid = 1'b0;
        // Scramble a/b while waiting: the captured vector must be used, not the live inputs.
        a_in = 1'($urandom);
        b_in = 1'($urandom);
        check_all(1'b0, 1'b1, 1'b0);
        repeat (SETTLE - 1) begin
            tick();
            check_all(1'b0, 1'b1, 1'b0);
        end
        tick();
        model_compare(a, b, c, bad);
        check_all(!m_done, 1'b0, bad);
    endtask

    task automatic do_clear(input bit use_rst);
        if (use_rst) rst_n = 1'b0;
        else clear = 1'b1;
        tick();
        rst_n = 1'b1;
        clear = 1'b0;
        model_reset();
        check_all(1'b1, 1'b0, 1'b0);
    endtask

    task automatic hold_done();
        vec_valid = 1'b1;
        tick();
        check_all(1'b0, 1'b0, 1'b0);
        vec_valid = 1'b0;
    endtask

    task automatic abort_cases(input bit use_rst);
        do_clear(use_rst);
        do_vec(1'b1, 1'b0, 1'b1, 1'b0);
        // Abort during WAIT with a wrong gate output that would otherwise count.
        vec_valid = 1'b1;
        a_in = 1'b0;
        b_in = 1'b0;
        c_in = 1'b1;
        tick();
        vec_valid = 1'b0;
        check_all(1'b0, 1'b1, 1'b0);
        do_clear(use_rst);
        repeat (SETTLE + 1) tick();
        check_all(1'b1, 1'b0, 1'b0);
        // Restart together with a vector offered in IDLE: the vector is dropped.
        vec_valid = 1'b1;
        a_in = 1'b1;
        b_in = 1'b1;
        do_clear(use_rst);
        vec_valid = 1'b0;
        repeat (SETTLE + 1) tick();
        check_all(1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        logic [1:0] v;
        logic       c;
        int         guard;
        rst_n = 1'b0;
        clear = 1'b0;
        vec_valid = 1'b0;
        a_in = 1'b0;
        b_in = 1'b0;
        c_in = 1'b0;
        model_reset();
        repeat (2) tick();
        rst_n = 1'b1;
        check_all(1'b1, 1'b0, 1'b0);

        // Good AND gate over all four vectors.
        do_vec(1'b0, 1'b0, 1'b0, 1'b0);
        do_vec(1'b0, 1'b1, 1'b0, 1'b0);
        do_vec(1'b1, 1'b0, 1'b0, 1'b0);
        do_vec(1'b1, 1'b1, 1'b1, 1'b0);
        hold_done();
        hold_done();

        // Faulty response on 01.
        do_clear(1'b0);
        do_vec(1'b0, 1'b1, 1'b1, 1'b0);
        do_vec(1'b0, 1'b0, 1'b0, 1'b0);
        do_vec(1'b1, 1'b0, 1'b0, 1'b0);
        do_vec(1'b1, 1'b1, 1'b1, 1'b0);
        hold_done();

        // Repeated vectors with vec_valid held high back to back.
        do_clear(1'b0);
        do_vec(1'b0, 1'b0, 1'b0, 1'b1);
        do_vec(1'b0, 1'b0, 1'b0, 1'b1);
        do_vec(1'b0, 1'b0, 1'b0, 1'b1);
        do_vec(1'b1, 1'b1, 1'b1, 1'b1);
        vec_valid = 1'b0;

        abort_cases(1'b0);
        abort_cases(1'b1);

        // Five wrong responses without completing coverage.
        do_clear(1'b0);
        do_vec(1'b0, 1'b1, 1'b1, 1'b0);
        do_vec(1'b0, 1'b0, 1'b1, 1'b0);
        do_vec(1'b0, 1'b0, 1'b1, 1'b1);
        do_vec(1'b0, 1'b1, 1'b1, 1'b1);
        do_vec(1'b0, 1'b0, 1'b1, 1'b0);
        vec_valid = 1'b0;

        // Randomized runs to completion.
        repeat (6) begin
            do_clear($urandom_range(0, 1) == 1);
            guard = 0;
            while (!m_done && guard < 40) begin
                v = 2'($urandom);
                c = v[1] & v[0];
                if ($urandom_range(0, 3) == 0) c = ~c;
                do_vec(v[1], v[0], c, 1'($urandom));
                guard++;
            end
            vec_valid = 1'b0;
            chk("random_run_done", done8, 1'b1);
            hold_done();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
